servo_pwm_rx: RTL

Receiver/decoder for the 50 Hz servo PWM stream produced by the team's servo controller. It runs on the same 10 kHz system clock (100 us tick) and measures the high width and period of each frame in ticks. It validates each frame and classifies it as LEFT, MID or RIGHT. It is used for loopback self-check of the servo output and for reading external servo-format command inputs.

---
 rtl/servo_pkg.sv | 36 +++
 rtl/pwm_sync_edge.sv | 32 +++
 rtl/servo_pwm_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM controller and its receiver/decoder.
package servo_pkg;

    // Decoded servo position encodings (2'b11 is never produced)
    localparam logic [1:0] POS_LEFT  = 2'b00;
    localparam logic [1:0] POS_MID   = 2'b01;
    localparam logic [1:0] POS_RIGHT = 2'b10;

    // Nominal pulse widths and frame period in 100 us ticks
    localparam int NOM_LEFT_W   = 7;
    localparam int NOM_MID_W    = 15;
    localparam int NOM_RIGHT_W  = 23;
    localparam int NOM_PERIOD   = 200;

    // Receiver frame-tracking states
    typedef enum logic [1:0] {
        S_SYNC = 2'b00,
        S_HIGH = 2'b01,
        S_LOW  = 2'b10
    } state_t;

    // Classify a measured high width against the LEFT/RIGHT thresholds
    function automatic logic [1:0] decode_pos(input logic [7:0] w,
                                              input logic [7:0] leftThr,
                                              input logic [7:0] rightThr);
        logic [1:0] p;
        p = POS_MID;
        if (w <= leftThr) begin
            p = POS_LEFT;
        end else if (w >= rightThr) begin
            p = POS_RIGHT;
        end
        return p;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus delay register producing single-cycle rise/fall strobes.
module pwm_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_delay;

    // Bring the asynchronous input into the clock domain and keep one cycle of history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_delay <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_delay <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_rise  = r_sync2 & ~r_delay;
    assign o_fall  = ~r_sync2 & r_delay;

endmodule

// File: rtl/servo_pwm_rx.sv
// Servo PWM receiver: measures width/period per frame, validates, decodes position, tracks lock.
module servo_pwm_rx
    import servo_pkg::*;
#(
    parameter int PERIOD_MIN = 190,
    parameter int PERIOD_MAX = 210,
    parameter int WIDTH_MIN  = 5,
    parameter int WIDTH_MAX  = 25,
    parameter int LEFT_THR   = 11,
    parameter int RIGHT_THR  = 19,
    parameter int TIMEOUT    = 250,
    parameter int LOCK_CNT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] width,
    output logic [8:0] period,
    output logic [1:0] pos,
    output logic       valid,
    output logic       err,
    output logic       locked
);

    localparam int GCW = $clog2(LOCK_CNT + 1);

    localparam logic [8:0]     C_PER_MIN = 9'(PERIOD_MIN);
    localparam logic [8:0]     C_PER_MAX = 9'(PERIOD_MAX);
    localparam logic [7:0]     C_W_MIN   = 8'(WIDTH_MIN);
    localparam logic [7:0]     C_W_MAX   = 8'(WIDTH_MAX);
    localparam logic [7:0]     C_L_THR   = 8'(LEFT_THR);
    localparam logic [7:0]     C_R_THR   = 8'(RIGHT_THR);
    localparam logic [8:0]     C_TIMEOUT = 9'(TIMEOUT);
    localparam logic [GCW-1:0] C_LOCK    = GCW'(LOCK_CNT);

    logic w_pwmS;
    logic w_rise;
    logic w_fall;

    state_t         r_state;
    state_t         w_nextState;
    logic           w_evalFrame;
    logic           w_timeout;
    logic           w_goodFrame;
    logic [GCW-1:0] w_goodCntNext;

    logic [7:0]     r_hiCnt;
    logic [8:0]     r_perCnt;
    logic [GCW-1:0] r_goodCnt;
    logic [7:0]     r_width;
    logic [8:0]     r_period;
    logic [1:0]     r_pos;
    logic           r_valid;
    logic           r_err;
    logic           r_locked;

    pwm_sync_edge u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_async (pwm_in),
        .o_level (w_pwmS),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_goodFrame = (r_perCnt >= C_PER_MIN) && (r_perCnt <= C_PER_MAX) &&
                         (r_hiCnt  >= C_W_MIN)   && (r_hiCnt  <= C_W_MAX);

    assign w_goodCntNext = (r_goodCnt >= C_LOCK) ? C_LOCK : r_goodCnt + GCW'(1);

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus frame-evaluation and timeout strobes; a rise beats a timeout
    always_comb begin
        w_nextState = r_state;
        w_evalFrame = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (w_rise) begin
                    w_nextState = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_perCnt >= C_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_SYNC;
                end else if (w_fall) begin
                    w_nextState = S_LOW;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_evalFrame = 1'b1;
                    w_nextState = S_HIGH;
                end else if (r_perCnt >= C_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_SYNC;
                end
            end
            default: begin
                w_nextState = S_SYNC;
            end
        endcase
    end

    // Saturating width/period counters; a rise restarts both at 1 to include the rise cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hiCnt  <= '0;
            r_perCnt <= '0;
        end else if (w_rise) begin
            r_hiCnt  <= 8'd1;
            r_perCnt <= 9'd1;
        end else begin
            if (r_perCnt != '1) begin
                r_perCnt <= r_perCnt + 9'd1;
            end
            if (w_pwmS && (r_hiCnt != '1)) begin
                r_hiCnt <= r_hiCnt + 8'd1;
            end
        end
    end

    // Publish good frames, flag bad frames/timeouts, and track consecutive-good lock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_width   <= '0;
            r_period  <= '0;
            r_pos     <= POS_MID;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_goodCnt <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_evalFrame) begin
                if (w_goodFrame) begin
                    r_width   <= r_hiCnt;
                    r_period  <= r_perCnt;
                    r_pos     <= decode_pos(r_hiCnt, C_L_THR, C_R_THR);
                    r_valid   <= 1'b1;
                    r_goodCnt <= w_goodCntNext;
                    r_locked  <= (w_goodCntNext == C_LOCK);
                end else begin
                    r_err     <= 1'b1;
                    r_goodCnt <= '0;
                    r_locked  <= 1'b0;
                end
            end else if (w_timeout) begin
                r_err     <= 1'b1;
                r_goodCnt <= '0;
                r_locked  <= 1'b0;
            end
        end
    end

    assign width  = r_width;
    assign period = r_period;
    assign pos    = r_pos;
    assign valid  = r_valid;
    assign err    = r_err;
    assign locked = r_locked;

endmodule
